// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM states,
// mode encoding and the parameter legality check.
package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_ADD = 1'b1;

  // True when DIGIT is a legal slice width for a WIDTH-bit operand.
  function automatic bit digit_divides(input int width, input int digit);
    return (width >= 1) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple of 1-bit add/subtract cells. In subtract
// mode the carry chain carries a borrow; in add mode it carries a carry.
module addsub_digit
  import addsub_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic             mode,
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             cin,
  output logic [DIGIT-1:0] res_d,
  output logic             cout,
  output logic             a_msb,
  output logic             b_msb
);

  logic w_ripple;

  // Ripple the carry/borrow through each bit of the slice, LSB first.
  always_comb begin
    // NOTE: blocking assignments here are deliberate; w_ripple must carry the
    // value produced by bit i into bit i+1 within the same evaluation.
    res_d    = '0;
    w_ripple = cin;
    for (int i = 0; i < DIGIT; i++) begin
      res_d[i] = a_d[i] ^ b_d[i] ^ w_ripple;
      if (mode == MODE_ADD) begin
        w_ripple = (a_d[i] & b_d[i]) | (w_ripple & (a_d[i] ^ b_d[i]));
      end else begin
        w_ripple = (~a_d[i] & b_d[i]) | (w_ripple & ~(a_d[i] ^ b_d[i]));
      end
    end
    cout = w_ripple;
  end

  // MSB-stage operand bits, used by the top to form signed overflow.
  assign a_msb = a_d[DIGIT-1];
  assign b_msb = b_d[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one WIDTH-bit operation per accepted start,
// DIGIT bits per clock through a single reusable digit slice.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             bout,
  output logic             overflow
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(N) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

  generate
    if (!digit_divides(WIDTH, DIGIT)) begin : g_bad_digit
      $error("serial_addsub: DIGIT must be >= 1 and divide WIDTH");
    end
  endgenerate

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sh;
  logic               r_mode;
  logic               r_c;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;
  logic               r_bout;
  logic               r_ovf;

  logic [DIGIT-1:0]   w_res_d;
  logic               w_cout;
  logic               w_a_msb;
  logic               w_b_msb;
  logic [WIDTH-1:0]   w_sh_next;
  logic               w_ovf;

  addsub_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .mode  (r_mode),
    .a_d   (r_a[DIGIT-1:0]),
    .b_d   (r_b[DIGIT-1:0]),
    .cin   (r_c),
    .res_d (w_res_d),
    .cout  (w_cout),
    .a_msb (w_a_msb),
    .b_msb (w_b_msb)
  );

  // New digit enters at the top of the result shadow; older digits move down.
  assign w_sh_next = (WIDTH'(w_res_d) << (WIDTH - DIGIT)) | (r_sh >> DIGIT);

  // Signed overflow: only meaningful on the final step, when the slice sees
  // the operand MSBs and produces the result MSB.
  assign w_ovf = (r_mode == MODE_ADD)
               ? ((w_a_msb == w_b_msb) && (w_sh_next[WIDTH-1] != w_a_msb))
               : ((w_a_msb != w_b_msb) && (w_sh_next[WIDTH-1] != w_a_msb));

  // Control FSM plus operand/result shifting and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath shadows are cleared too, so an aborted operation
      // leaves nothing behind and every flop has a known post-reset value.
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_sh     <= '0;
      r_mode   <= MODE_SUB;
      r_c      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= ST_RUN;
            r_a     <= a;
            r_b     <= b;
            r_mode  <= mode;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          r_a   <= r_a >> DIGIT;
          r_b   <= r_b >> DIGIT;
          r_sh  <= w_sh_next;
          r_c   <= w_cout;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_STEP) begin
            r_state  <= ST_DONE;
            r_result <= w_sh_next;
            r_bout   <= w_cout;
            r_ovf    <= w_ovf;
            r_done   <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign bout     = r_bout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: three instances (8/1, 8/4, 1/1)
// checked every cycle against an arithmetic reference model, plus literal
// expectations for the hand-worked cases.
module tb_serial_addsub;

  localparam int NI = 3;

  typedef struct packed {
    logic       ovf;
    logic       bout;
    logic [7:0] res;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_start [NI];
  logic       s_mode  [NI];
  logic [7:0] s_a     [NI];
  logic [7:0] s_b     [NI];
  logic       d_busy  [NI];
  logic       d_done  [NI];
  logic       d_bout  [NI];
  logic       d_ovf   [NI];
  logic [7:0] d_res   [NI];
  logic       w2_res;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(s_start[0]), .mode(s_mode[0]),
    .a(s_a[0]), .b(s_b[0]), .busy(d_busy[0]), .done(d_done[0]),
    .result(d_res[0]), .bout(d_bout[0]), .overflow(d_ovf[0])
  );

  serial_addsub #(.WIDTH(8), .DIGIT(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(s_start[1]), .mode(s_mode[1]),
    .a(s_a[1]), .b(s_b[1]), .busy(d_busy[1]), .done(d_done[1]),
    .result(d_res[1]), .bout(d_bout[1]), .overflow(d_ovf[1])
  );

  serial_addsub #(.WIDTH(1), .DIGIT(1)) u_dut2 (
    .clk(clk), .rst(rst), .start(s_start[2]), .mode(s_mode[2]),
    .a(s_a[2][0:0]), .b(s_b[2][0:0]), .busy(d_busy[2]), .done(d_done[2]),
    .result(w2_res), .bout(d_bout[2]), .overflow(d_ovf[2])
  );
  assign d_res[2] = {7'b0, w2_res};

  function automatic int w_of(input int i);
    return (i == 2) ? 1 : 8;
  endfunction

  function automatic int n_of(input int i);
    case (i)
      0:       return 8;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  // Reference arithmetic: exact integer result, then wrap, borrow/carry and
  // signed-range overflow derived from the mathematical definitions.
  function automatic exp_t calc(input int w, input bit md, input int ua, input int ub);
    exp_t r;
    int   lim, ex, sa, sb, sx;
    lim   = 1 << w;
    ua    = ua % lim;
    ub    = ub % lim;
    ex    = md ? (ua + ub) : (ua - ub);
    r.res = 8'(((ex % lim) + lim) % lim);
    r.bout = md ? (ex >= lim) : (ex < 0);
    sa    = (ua >= lim / 2) ? (ua - lim) : ua;
    sb    = (ub >= lim / 2) ? (ub - lim) : ub;
    sx    = md ? (sa + sb) : (sa - sb);
    r.ovf = (sx < -(lim / 2)) || (sx > (lim / 2 - 1));
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Timing model: an accepted start schedules done N edges later; busy
  // spans from the start edge until one edge after done.
  int   m_cnt  [NI];
  exp_t m_pend [NI];
  exp_t m_out  [NI];

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m_cnt[i] <= 0;
        m_out[i] <= '0;
      end else if (m_cnt[i] == 0) begin
        if (s_start[i]) begin
          m_cnt[i]  <= n_of(i) + 1;
          m_pend[i] <= calc(w_of(i), s_mode[i], int'(s_a[i]), int'(s_b[i]));
        end
      end else begin
        m_cnt[i] <= m_cnt[i] - 1;
        if (m_cnt[i] == 2) m_out[i] <= m_pend[i];
      end
    end
  end

  // Every-cycle comparison of all outputs of all instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < NI; i++) begin
        check($sformatf("cycle_i%0d {busy,done,ovf,bout,res}", i),
              {20'd0, d_busy[i], d_done[i], d_ovf[i], d_bout[i], d_res[i]},
              {20'd0, (m_cnt[i] != 0), (m_cnt[i] == 1), m_out[i]});
      end
    end
  end

  // Caller is at a negedge with the instance idle. Returns the number of
  // edges from the start edge (inclusive) to the edge that raised done.
  task automatic run_op(input int ii, input bit md, input logic [7:0] av,
                        input logic [7:0] bv, output int edges);
    s_start[ii] = 1'b1;
    s_mode[ii]  = md;
    s_a[ii]     = av;
    s_b[ii]     = bv;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    s_start[ii] = 1'b0;
    while (!d_done[ii] && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic lit(input string name, input bit md, input logic [7:0] av,
                     input logic [7:0] bv, input logic [7:0] er,
                     input logic eb, input logic eo);
    int e;
    check({name, " model"}, 32'(calc(8, md, int'(av), int'(bv))), {22'd0, eo, eb, er});
    @(negedge clk);
    run_op(0, md, av, bv, e);
    check({name, " latency"}, e, 9);
    check({name, " dut"}, {22'd0, d_ovf[0], d_bout[0], d_res[0]}, {22'd0, eo, eb, er});
  endtask

  logic [2:0] tt [0:7];

  initial begin
    int         e, dc;
    logic [7:0] av, bv;
    bit         md;
    exp_t       m;

    // {res, bout, ovf} for WIDTH=1, indexed by {mode, a, b}
    tt = '{3'b000, 3'b111, 3'b100, 3'b000, 3'b000, 3'b100, 3'b100, 3'b011};

    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      s_start[i] = 1'b0; s_mode[i] = 1'b0; s_a[i] = '0; s_b[i] = '0;
    end
    @(posedge clk);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset state", {27'd0, d_busy[0], d_done[0], d_ovf[0], d_bout[0], |d_res[0]}, 32'd0);

    // Directed cases on the 8/1 instance
    lit("sub 05-03", 1'b0, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    lit("sub 03-05", 1'b0, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    lit("sub 80-01", 1'b0, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    lit("add 7F+01", 1'b1, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    lit("add FF+01", 1'b1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);

    // start pulses during RUN must be ignored
    @(negedge clk);
    s_start[0] = 1'b1; s_mode[0] = 1'b0; s_a[0] = 8'h5A; s_b[0] = 8'h33;
    @(negedge clk);
    dc = 0;
    for (int c = 1; c <= 14; c++) begin
      if (d_done[0]) begin
        dc++;
        check("ignore result", {22'd0, d_ovf[0], d_bout[0], d_res[0]}, {22'd0, 2'b00, 8'h27});
      end
      if (c == 3 || c == 6) begin
        s_start[0] = 1'b1; s_mode[0] = 1'b1; s_a[0] = 8'hFF; s_b[0] = 8'h01;
      end else begin
        s_start[0] = 1'b0;
      end
      @(negedge clk);
    end
    check("ignore done pulses", dc, 1);

    // Reset in the middle of a RUN
    s_start[0] = 1'b1; s_mode[0] = 1'b0; s_a[0] = 8'h40; s_b[0] = 8'h11;
    @(negedge clk);
    s_start[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid-run reset", {22'd0, d_busy[0], d_done[0], d_res[0]}, 32'd0);
    rst = 1'b0;
    run_op(0, 1'b0, 8'h10, 8'h01, e);
    check("post-reset latency", e, 9);
    check("post-reset result", {22'd0, d_ovf[0], d_bout[0], d_res[0]}, {22'd0, 2'b00, 8'h0F});

    // 8/4 instance: corners then random operands
    for (int t = 0; t < 34; t++) begin
      case (t)
        0: begin md = 1'b0; av = 8'h00; bv = 8'h00; end
        1: begin md = 1'b0; av = 8'h00; bv = 8'hFF; end
        2: begin md = 1'b1; av = 8'hFF; bv = 8'hFF; end
        3: begin md = 1'b1; av = 8'h80; bv = 8'h80; end
        default: begin
          md = 1'($urandom_range(0, 1));
          av = 8'($urandom);
          bv = 8'($urandom);
        end
      endcase
      @(negedge clk);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(1, md, av, bv, e);
      check($sformatf("w8d4 latency #%0d", t), e, 3);
      check($sformatf("w8d4 result #%0d", t),
            {22'd0, d_ovf[1], d_bout[1], d_res[1]},
            32'(calc(8, md, int'(av), int'(bv))));
    end

    // 8/4 instance: start held high gives back-to-back operations
    @(negedge clk);
    dc = 0;
    s_start[1] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      s_mode[1] = 1'($urandom_range(0, 1));
      s_a[1]    = 8'($urandom);
      s_b[1]    = 8'($urandom);
      @(negedge clk);
      if (d_done[1]) dc++;
    end
    s_start[1] = 1'b0;
    check("back-to-back done count", dc, 5);

    // 1/1 instance: full truth table over mode, a, b
    for (int k = 0; k < 8; k++) begin
      md = k[2];
      av = {7'd0, k[1]};
      bv = {7'd0, k[0]};
      m  = calc(1, md, int'(av), int'(bv));
      check($sformatf("w1 model case %0d", k), {29'd0, m.res[0], m.bout, m.ovf}, {29'd0, tt[k]});
      @(negedge clk);
      run_op(2, md, av, bv, e);
      check($sformatf("w1 latency case %0d", k), e, 2);
      check($sformatf("w1 dut case %0d", k), {29'd0, d_res[2][0], d_bout[2], d_ovf[2]}, {29'd0, tt[k]});
    end

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised bit-serial adder/subtractor: one `WIDTH`-bit operation per `start`, processed `DIGIT` bits per clock from LSB upward through a single reusable digit slice and a registered borrow/carry. It generalises the team's single-bit full-subtractor cell to multi-bit operands, adds an add/subtract mode and signed-overflow detection, and gives a start/busy/done handshake. It is the low-area arithmetic unit for datapaths that can trade latency for gates.

## Interface
- `WIDTH`, 8, operand/result width; ≥1.
- `DIGIT`, 1, bits processed per cycle; must divide `WIDTH`. Illegal values are a compile-time error.
- `clk` in 1: the single clock; everything is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request; sampled only in IDLE.
- `mode` in 1: 0 = subtract (a−b), 1 = add (a+b); latched with `start`.
- `a` in `WIDTH`: minuend/augend; latched with `start`.
- `b` in `WIDTH`: subtrahend/addend; latched with `start`.
- `busy` out 1: high in RUN and DONE.
- `done` out 1: one-cycle pulse; result valid.
- `result` out `WIDTH`: a−b or a+b, modulo 2^WIDTH.
- `bout` out 1: borrow-out in subtract mode (a<b unsigned); carry-out in add mode.
- `overflow` out 1: two's-complement signed overflow of the operation.

## Operation
- States are IDLE, RUN and DONE. Define N = WIDTH/DIGIT.
- IDLE→RUN: on `start`=1. On that edge, latch `a`, `b` and `mode` into shift registers, clear the borrow/carry register, and clear the step counter.
- RUN: each cycle, the digit slice combines the low `DIGIT` bits of the a/b shift registers with the borrow/carry register.
  - Digit output shifts into the top of the result shift register.
  - Operand registers shift right by `DIGIT`.
  - The borrow/carry register takes the slice output.
  - The counter increments.
- RUN→DONE: on the edge that processes step N−1. On that edge, `result`, `bout` and `overflow` update.
- DONE→IDLE: unconditionally after one cycle.
- `result`, `bout` and `overflow` hold their values until the next accepted `start` completes. They do not change during RUN; only internal shadow registers shift.
- `start` is ignored in RUN and DONE. There is no queueing.
- Subtract: result = (a−b) mod 2^WIDTH; bout = (a <u b); overflow = (a[MSB]≠b[MSB]) & (result[MSB]≠a[MSB]).
- Add: result = (a+b) mod 2^WIDTH; bout = carry-out; overflow = (a[MSB]=b[MSB]) & (result[MSB]≠a[MSB]).
- `rst`=1 takes priority over everything, including mid-RUN. It aborts the operation and discards partial results.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `result`=0, `bout`=0, `overflow`=0; counter and borrow cleared.
- `start` sampled at edge k:
  - `busy`=1 from cycle k+1.
  - RUN occupies edges k+1…k+N.
  - `done`=1 and outputs valid during the cycle after edge k+N.
  - `busy` falls after edge k+N+1.
  - Latency from start to done is N+1 edges.
- Throughput: the earliest next `start` is accepted at edge k+N+2, i.e. the first IDLE cycle.
- `start` held high continuously gives back-to-back operations with one IDLE cycle between them.
- `rst` asserted during any cycle: the state is IDLE and outputs are at reset values after that edge. A `start` on the cycle after reset release is accepted normally.
- WIDTH=DIGIT (N=1): one RUN cycle, then DONE.

## Structure
- Shared package/header `addsub_pkg`: state encoding (IDLE/RUN/DONE), mode constants `MODE_SUB`=0 and `MODE_ADD`=1, and the `DIGIT`-divides-`WIDTH` check.
- Sub-module `addsub_digit`: combinational `DIGIT`-bit ripple of 1-bit add/subtract cells.
  - Inputs: mode, a_d, b_d, cin/bin.
  - Outputs: res_d, cout/bout.
  - Also exposes the MSB-stage inputs so the top can form `overflow` on the final step.
- Top: FSM, counter of width clog2(N)+1, operand/result shift registers, borrow/carry flop.

## Test plan
- Basic subtract, WIDTH=8, DIGIT=1, sub 0x05−0x03 → `result`=0x02, `bout`=0, `overflow`=0, `done` exactly 9 edges after the `start` edge.
- Borrow and signed overflow in subtract:
  - sub 0x03−0x05 → 0xFE, `bout`=1, `overflow`=0.
  - sub 0x80−0x01 → 0x7F, `bout`=0, `overflow`=1.
- Add mode:
  - add 0x7F+0x01 → 0x80, `bout`=0, `overflow`=1.
  - add 0xFF+0x01 → 0x00, `bout`=1, `overflow`=0.
- `start` pulsed at cycles 3 and 6 of a RUN with different operands → ignored; first result unchanged; `done` pulses once.
- `rst` asserted at RUN cycle 4 → next cycle `busy`=0, `done`=0, `result`=0. A following sub 0x10−0x01 → 0x0F with normal latency.
- Parameter sweep:
  - WIDTH=8, DIGIT=4: `done` 3 edges after `start`; random operands vs reference model.
  - WIDTH=1: all 8 (a,b,bin-equivalent) cases match the full-subtractor truth table.
